// File: rtl/npc_redirect_queue_if.sv
// Handshake bundle between the ID stage, the next-PC redirect queue and the PC register.
// The slave modport is the queue's view; the master modport is the driving environment.
interface npc_redirect_queue_if #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          I_in_valid;
  logic          O_in_ready;
  logic [AW-1:0] I_pc;
  logic [AW-1:0] I_snpc;
  logic [DW-1:0] I_rs1_data;
  logic [DW-1:0] I_imm;
  logic [DW-1:0] I_intr_pc;
  logic [4:0]    I_dnpc_sel;
  logic          I_flush;
  logic          O_dnpc_valid;
  logic          I_dnpc_ready;
  logic [AW-1:0] O_dnpc;
  logic          O_misalign;
  logic [CW-1:0] O_count;

  modport slave (
    input  I_in_valid, I_pc, I_snpc, I_rs1_data, I_imm, I_intr_pc,
           I_dnpc_sel, I_flush, I_dnpc_ready,
    output O_in_ready, O_dnpc_valid, O_dnpc, O_misalign, O_count
  );

  modport master (
    output I_in_valid, I_pc, I_snpc, I_rs1_data, I_imm, I_intr_pc,
           I_dnpc_sel, I_flush, I_dnpc_ready,
    input  O_in_ready, O_dnpc_valid, O_dnpc, O_misalign, O_count
  );
endinterface

// File: rtl/npc_redirect_queue.sv
// Next-PC target generator with a small in-order FIFO of pending redirects.
// The target bypasses the FIFO when it is empty and the PC register is ready.
module npc_redirect_queue #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int DEPTH = 2,
  parameter int C_EXT = 0
) (
  input logic                I_clk,
  input logic                I_rst,
  npc_redirect_queue_if.slave io_bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Returns {misalign, target}; priority intr > jalr > jal/branch > snpc.
  function automatic logic [AW:0] calc_target(
    input logic [4:0]    sel,
    input logic [AW-1:0] pc,
    input logic [AW-1:0] snpc,
    input logic [AW-1:0] rs1,
    input logic [AW-1:0] imm,
    input logic [AW-1:0] intr
  );
    logic [AW-1:0] t;
    logic          chk;
    t   = snpc;
    chk = 1'b0;
    if (sel[4]) begin
      t = intr;
    end else if (sel[3]) begin
      t   = (rs1 + imm) & ~AW'(1);
      chk = 1'b1;
    end else if (sel[2] || sel[1]) begin
      t   = pc + imm;
      chk = 1'b1;
    end
    return {chk && (C_EXT == 0) && t[1], t};
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  logic [AW-1:0] r_mem [DEPTH];
  logic          r_mis [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic [AW:0]   w_calc;
  logic [AW-1:0] w_tgt;
  logic          w_tmis;
  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  assign w_calc = calc_target(io_bus.I_dnpc_sel, io_bus.I_pc, io_bus.I_snpc,
                              io_bus.I_rs1_data[AW-1:0], io_bus.I_imm[AW-1:0],
                              io_bus.I_intr_pc[AW-1:0]);
  assign w_tgt  = w_calc[AW-1:0];
  assign w_tmis = w_calc[AW];

  generate
    if (DW > AW) begin : g_wide
      logic w_unused_hi;
      assign w_unused_hi = ^{io_bus.I_rs1_data[DW-1:AW], io_bus.I_imm[DW-1:AW],
                             io_bus.I_intr_pc[DW-1:AW]};
    end
  endgenerate

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_accept = io_bus.I_in_valid && io_bus.O_in_ready;
  // An accepted target goes straight out when the queue is empty and the PC register takes it.
  assign w_push   = w_accept && !(w_empty && io_bus.I_dnpc_ready);
  assign w_pop    = !io_bus.I_flush && !w_empty && io_bus.I_dnpc_ready;

  assign io_bus.O_in_ready   = !w_full && !io_bus.I_flush;
  assign io_bus.O_dnpc_valid = !io_bus.I_flush && (!w_empty || io_bus.I_in_valid);
  assign io_bus.O_dnpc       = w_empty ? w_tgt  : r_mem[r_rptr];
  assign io_bus.O_misalign   = w_empty ? w_tmis : r_mis[r_rptr];
  assign io_bus.O_count      = r_count;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
        r_mis[i] <= 1'b0;
      end
    end else if (io_bus.I_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_tgt;
        r_mis[r_wptr] <= w_tmis;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_npc_redirect_queue.sv
// Directed plus randomized bench for npc_redirect_queue (AW=32, DW=64, DEPTH=2, C_EXT=0)
// with a scoreboard queue of expected {misalign, dnpc} in acceptance order.
module tb_npc_redirect_queue;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 2;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [32:0] sb[$];
  logic [31:0] last_dnpc;
  logic        last_mis;

  npc_redirect_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

  npc_redirect_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .C_EXT(0)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [4:0] sel, input logic [31:0] pc,
                                        input logic [31:0] snpc, input logic [63:0] rs1,
                                        input logic [63:0] imm, input logic [63:0] intr);
    logic [31:0] t;
    logic        m;
    m = 1'b0;
    if (sel[4]) t = intr[31:0];
    else if (sel[3]) begin
      t = rs1[31:0] + imm[31:0];
      t[0] = 1'b0;
      m = t[1];
    end else if (sel[2] | sel[1]) begin
      t = pc + imm[31:0];
      m = t[1];
    end else t = snpc;
    return {m, t};
  endfunction

  // One clock: drive at posedge+1, check on the falling edge, update scoreboard, advance.
  task automatic cyc(input logic v, input logic [4:0] sel, input logic [31:0] pc,
                     input logic [31:0] snpc, input logic [63:0] rs1, input logic [63:0] imm,
                     input logic [63:0] intr, input logic rdy, input logic fl);
    logic        exp_rdy;
    logic        exp_vld;
    logic [32:0] e;
    bus.I_in_valid   = v;
    bus.I_dnpc_sel   = sel;
    bus.I_pc         = pc;
    bus.I_snpc       = snpc;
    bus.I_rs1_data   = rs1;
    bus.I_imm        = imm;
    bus.I_intr_pc    = intr;
    bus.I_dnpc_ready = rdy;
    bus.I_flush      = fl;
    #4;
    exp_rdy = (sb.size() < DEPTH) && !fl;
    exp_vld = !fl && (sb.size() > 0 || v);
    chk("count", 64'(bus.O_count), 64'(sb.size()));
    chk("in_ready", 64'(bus.O_in_ready), 64'(exp_rdy));
    chk("dnpc_valid", 64'(bus.O_dnpc_valid), 64'(exp_vld));
    last_dnpc = bus.O_dnpc;
    last_mis  = bus.O_misalign;
    if (v && exp_rdy) sb.push_back(model(sel, pc, snpc, rs1, imm, intr));
    if (exp_vld && rdy) begin
      total++;
      assert (sb.size() > 0)
      else begin
        bad++;
        $error("FAIL sb_empty observed=0x%0h expected=no_output", bus.O_dnpc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dnpc", 64'(bus.O_dnpc), 64'(e[31:0]));
        chk("misalign", 64'(bus.O_misalign), 64'(e[32]));
      end
    end
    if (fl) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 5'b00001, 32'h0, 32'h0, 64'h0, 64'h0, 64'h0, rdy, 1'b0);
  endtask

  task automatic push_snpc(input logic [31:0] snpc, input logic rdy);
    cyc(1'b1, 5'b00001, 32'h0, snpc, 64'h0, 64'h0, 64'h0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    bus.I_in_valid = 1'b0;
    bus.I_flush    = 1'b0;
    bus.I_dnpc_sel = 5'b00001;
    bus.I_snpc     = 32'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #3;
    chk("rst_count", 64'(bus.O_count), 64'h0);
    chk("rst_valid", 64'(bus.O_dnpc_valid), 64'h0);
    chk("rst_misalign", 64'(bus.O_misalign), 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.I_in_valid   = 1'b0;
    bus.I_dnpc_sel   = 5'b0;
    bus.I_pc         = '0;
    bus.I_snpc       = '0;
    bus.I_rs1_data   = '0;
    bus.I_imm        = '0;
    bus.I_intr_pc    = '0;
    bus.I_dnpc_ready = 1'b0;
    bus.I_flush      = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Bypass on empty queue
    cyc(1'b1, 5'b00100, 32'h8000_0000, 32'h0, 64'h0, 64'h10, 64'h0, 1'b1, 1'b0);
    chk("bypass_dnpc", 64'(last_dnpc), 64'h8000_0010);
    idle(1'b1);

    // Jalr target alignment
    cyc(1'b1, 5'b01000, 32'h0, 32'h0, 64'h8000_1003, 64'h2, 64'h0, 1'b1, 1'b0);
    chk("jalr_dnpc", 64'(last_dnpc), 64'h8000_1004);
    chk("jalr_mis", 64'(last_mis), 64'h0);
    cyc(1'b1, 5'b01000, 32'h0, 32'h0, 64'h8000_1001, 64'h1, 64'h0, 1'b1, 1'b0);
    chk("jalr_dnpc2", 64'(last_dnpc), 64'h8000_1002);
    chk("jalr_mis2", 64'(last_mis), 64'h1);

    // Back-pressure fill and in-order drain
    push_snpc(32'h8000_0004, 1'b0);
    push_snpc(32'h8000_0008, 1'b0);
    push_snpc(32'h8000_000c, 1'b0);
    chk("full_count", 64'(bus.O_count), 64'h2);
    push_snpc(32'h8000_000c, 1'b1);
    chk("drain0", 64'(last_dnpc), 64'h8000_0004);
    push_snpc(32'h8000_000c, 1'b1);
    chk("drain1", 64'(last_dnpc), 64'h8000_0008);
    idle(1'b1);
    chk("drain2", 64'(last_dnpc), 64'h8000_000c);
    idle(1'b1);

    // Simultaneous push and pop at count=1
    push_snpc(32'h0000_0100, 1'b0);
    push_snpc(32'h0000_0200, 1'b1);
    chk("pp_count", 64'(bus.O_count), 64'h1);
    idle(1'b1);
    chk("pp_head", 64'(last_dnpc), 64'h0000_0200);
    idle(1'b1);

    // Flush with a full queue and a pending request
    push_snpc(32'h0000_0300, 1'b0);
    push_snpc(32'h0000_0304, 1'b0);
    cyc(1'b1, 5'b00001, 32'h0, 32'h0000_0308, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Priority with every select bit set
    cyc(1'b1, 5'b11111, 32'h1000, 32'h2000, 64'h3000, 64'h4, 64'h8000_0100, 1'b1, 1'b0);
    chk("prio_dnpc", 64'(last_dnpc), 64'h8000_0100);

    // Reset with two pending entries
    push_snpc(32'h0000_0400, 1'b0);
    push_snpc(32'h0000_0404, 1'b0);
    do_reset();
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
